// File: rtl/bram_fifo_pkg.sv
// Shared definitions for the block-RAM FIFO slice: default frame-buffer word
// width and an elaboration-time log2 helper.
package bram_fifo_pkg;

  localparam int FB_DATA_W = 16;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/bram_fifo_sdp_ram.sv
// Simple dual-port RAM, one clock, registered read; infers as block RAM and
// can stand in for a bare single-clock bRAM.
module sdp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bram_fifo.sv
// Single-clock FIFO on an inferred SDP block RAM with valid/ready on both
// sides and a two-entry first-word-fall-through output stage.
module bram_fifo
  import bram_fifo_pkg::*;
#(
  parameter int DATA_W   = FB_DATA_W,
  parameter int ADDR_W   = 4,
  parameter int AFULL_TH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AFULL_C = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_q, ram_cnt;
  logic              ovf_q;
  logic              push, pop, issue;
  logic [2:0]        pend;

  logic              rd_vld_p1;
  logic [DATA_W-1:0] rdata_p1;

  logic              head_vld_p2, skid_vld_p2;
  logic [DATA_W-1:0] head_data_p2, skid_data_p2;
  logic              head_vld_n, skid_vld_n;
  logic [DATA_W-1:0] head_data_n, skid_data_n;

  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AFULL_C);
  assign s_ready     = ~full;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign m_valid     = head_vld_p2;
  assign m_data      = head_data_p2;

  assign push = s_valid && s_ready;
  assign pop  = head_vld_p2 && m_ready;

  // Words already committed to the output stage, including one still in the RAM read.
  assign pend  = {2'b0, head_vld_p2} + {2'b0, skid_vld_p2} + {2'b0, rd_vld_p1};
  assign issue = (ram_cnt != '0) && (pend < (3'd2 + {2'b0, pop}));

  // ---- stage p0 -> p1: RAM write and read issue ----
  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (s_data),
    .raddr (rd_ptr),
    .re    (issue),
    .rdata (rdata_p1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      count_q   <= '0;
      rd_vld_p1 <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_ONE;
      if (issue) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, issue})
        2'b10:   ram_cnt <= ram_cnt + CNT_ONE;
        2'b01:   ram_cnt <= ram_cnt - CNT_ONE;
        default: ram_cnt <= ram_cnt;
      endcase
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      rd_vld_p1 <= issue;
      if (s_valid && !s_ready) ovf_q <= 1'b1;
    end
  end

  // ---- stage p1 -> p2: head/skid output buffer ----
  always_comb begin
    head_vld_n  = head_vld_p2 & ~pop;
    head_data_n = head_data_p2;
    skid_vld_n  = skid_vld_p2;
    skid_data_n = skid_data_p2;
    if (!head_vld_n && skid_vld_n) begin
      head_vld_n  = 1'b1;
      head_data_n = skid_data_p2;
      skid_vld_n  = 1'b0;
    end
    if (rd_vld_p1) begin
      if (!head_vld_n) begin
        head_vld_n  = 1'b1;
        head_data_n = rdata_p1;
      end else begin
        skid_vld_n  = 1'b1;
        skid_data_n = rdata_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_vld_p2 <= 1'b0;
      skid_vld_p2 <= 1'b0;
    end else begin
      head_vld_p2 <= head_vld_n;
      skid_vld_p2 <= skid_vld_n;
    end
  end

  // m_data is visible on the port, so it is cleared with the control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_data_p2 <= '0;
      skid_data_p2 <= '0;
    end else begin
      head_data_p2 <= head_data_n;
      skid_data_p2 <= skid_data_n;
    end
  end

endmodule

// File: tb/tb_bram_fifo.sv
// Scoreboard bench for bram_fifo: stimulus queues expected words, a negedge
// monitor pops and compares every word the FIFO hands out.
module tb_bram_fifo;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W:0]   count;
  logic              empty, full, almost_full, overflow;

  bram_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_TH(12)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .count(count),
    .empty(empty), .full(full), .almost_full(almost_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int pop_cnt  = 0;
  int max_cnt  = 0;
  logic [DATA_W-1:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while ((sb.size() != 0 || !empty) && n < budget) begin
      tick();
      n++;
    end
    m_ready = 1'b0;
    chk({name, "_timeout"}, (n < budget), 1);
    chk({name, "_empty"}, empty, 1);
  endtask

  // Monitor: pops at the coming edge are decided by now, so compare here.
  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] stall_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, stall_data);
      end
      if (m_valid && m_ready) begin
        pop_cnt++;
        if (sb.size() == 0) chk("unexpected_word", 1, 0);
        else chk("data_order", m_data, sb.pop_front());
      end
      if (count > max_cnt) max_cnt = count;
      stall_prev <= m_valid && !m_ready;
      stall_data <= m_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] w;

    // Reset then idle
    do_reset();
    tick();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_m_data", m_data, 0);

    // Single word: visible two edges after the push edge
    s_valid = 1'b1; s_data = 16'hA5A5; sb.push_back(16'hA5A5);
    tick();
    s_valid = 1'b0;
    chk("lat_n", m_valid, 0);
    tick();
    chk("lat_n1", m_valid, 0);
    tick();
    chk("lat_n2_valid", m_valid, 1);
    chk("lat_n2_data", m_data, 16'hA5A5);
    chk("lat_n2_count", count, 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("single_empty", empty, 1);

    // Fill to DEPTH, then one rejected attempt
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = DATA_W'(i); sb.push_back(DATA_W'(i));
      tick();
      chk("fill_count", count, i + 1);
      chk("fill_afull", almost_full, (i + 1 >= 12));
    end
    chk("fill_full", full, 1);
    chk("fill_s_ready", s_ready, 0);
    s_data = 16'hDEAD;
    tick();
    s_valid = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    drain("fill_drain", 40);
    chk("ovf_sticky", overflow, 1);
    do_reset();
    tick();
    chk("ovf_cleared", overflow, 0);

    // Streaming at full rate across two pointer wraps
    pop_cnt = 0; max_cnt = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      w = DATA_W'($urandom);
      s_valid = 1'b1; s_data = w; sb.push_back(w);
      tick();
    end
    s_valid = 1'b0;
    chk("stream_pops", pop_cnt, 37);
    chk("stream_max_count", max_cnt, 3);
    drain("stream_drain", 20);

    // Random valid and ready
    for (int i = 0; i < 1000; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      w = DATA_W'($urandom);
      s_data = w;
      if (s_valid && s_ready) sb.push_back(w);
      tick();
    end
    drain("bp_drain", 60);

    // Reset while a read is in flight
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1; s_data = DATA_W'(16'h0100 + i); sb.push_back(DATA_W'(16'h0100 + i));
      tick();
    end
    s_valid = 1'b0;
    tick(); tick(); tick();
    chk("mid_count7", count, 7);
    s_valid = 1'b1; s_data = 16'h0177; sb.push_back(16'h0177); m_ready = 1'b1;
    tick();
    chk("mid_count_hold", count, 7);
    s_valid = 1'b0; m_ready = 1'b0; rst = 1'b1;
    sb.delete();
    tick();
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_count", count, 0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("mid_no_stale", m_valid, 0);
    s_valid = 1'b1; s_data = 16'h1234; sb.push_back(16'h1234);
    tick();
    s_valid = 1'b0;
    tick(); tick();
    chk("mid_fresh_data", m_data, 16'h1234);
    drain("mid_drain", 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
